// File: rtl/avr_io_pkg.sv
// Shared definitions for avr_cpu memory-mapped I/O blocks: register offsets,
// status bit layout and the UART transmitter state encoding.
package avr_io_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  // Register offsets within the 4-byte window
  localparam logic [1:0] OFS_UDR    = 2'd0;
  localparam logic [1:0] OFS_USR    = 2'd1;
  localparam logic [1:0] OFS_UBRR_L = 2'd2;
  localparam logic [1:0] OFS_UBRR_H = 2'd3;

  // USR bit positions
  localparam int unsigned USR_FULL  = 0;
  localparam int unsigned USR_EMPTY = 1;
  localparam int unsigned USR_BUSY  = 2;
  localparam int unsigned USR_OVF   = 3;

  // USR read payload; field order mirrors the bit positions above
  typedef struct packed {
    logic [3:0] rsvd;
    logic       ovf;
    logic       busy;
    logic       empty;
    logic       full;
  } usr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A programmed divisor of zero behaves as one clock per bit
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; push when full and pop when
// empty are ignored. DEPTH must be a power of two so pointers wrap naturally.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_push_c = push & ~full_c;
  assign do_pop_c  = pop & ~empty_c;
  assign rdata_c   = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avr_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the avr_cpu data bus: byte FIFO,
// programmable clocks-per-bit divisor, sticky overflow flag and an
// empty/idle interrupt level.
module avr_io_uart_tx
  import avr_io_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE  = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIVISOR    = 417
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_addr,
  input  logic        data_wen,
  input  logic        data_ren,
  input  logic [7:0]  data_write,
  output logic [7:0]  data_read,
  output logic        data_hit,
  output logic        uart_tx,
  output logic        irq_empty
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic [ADDR_W-1:0] offset_c;
  logic              in_win_c;
  logic [1:0]        reg_sel_c;
  logic              wr_c;
  logic              rd_c;
  logic              push_req_c;
  logic              fifo_push_c;
  logic              ovf_set_c;
  logic              usr_rd_c;
  logic [DATA_W-1:0] reg_rdata_c;
  usr_t              usr_c;

  // Control registers
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  div_eff_c;
  logic              overflow;

  // FIFO interface
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop_c;

  // Transmitter
  tx_state_t         state;
  tx_state_t         state_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_n;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DIV_W-1:0]  baud_cnt_n;
  logic              tx_n;

  // Window decode tolerates an unaligned base; wraparound falls outside
  assign offset_c    = data_addr - ADDR_BASE;
  assign in_win_c    = (offset_c[ADDR_W-1:2] == '0);
  assign reg_sel_c   = offset_c[1:0];
  assign wr_c        = data_wen & in_win_c;
  assign rd_c        = data_ren & in_win_c;
  assign push_req_c  = wr_c & (reg_sel_c == OFS_UDR);
  assign fifo_push_c = push_req_c & ~fifo_full;
  assign ovf_set_c   = push_req_c & fifo_full;
  assign usr_rd_c    = rd_c & (reg_sel_c == OFS_USR);
  assign div_eff_c   = eff_divisor(divisor);

  assign usr_c.rsvd  = 4'h0;
  assign usr_c.ovf   = overflow;
  assign usr_c.busy  = (state != IDLE);
  assign usr_c.empty = fifo_empty;
  assign usr_c.full  = fifo_full;

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push_c),
    .wdata   (data_write),
    .pop     (pop_c),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // Register read mux; UDR reads as zero
  always_comb begin
    reg_rdata_c = '0;
    case (reg_sel_c)
      OFS_USR:    reg_rdata_c = usr_c;
      OFS_UBRR_L: reg_rdata_c = divisor[7:0];
      OFS_UBRR_H: reg_rdata_c = divisor[15:8];
      default:    reg_rdata_c = '0;
    endcase
  end

  // One-cycle read response, zero when the access was not ours
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_read <= '0;
      data_hit  <= 1'b0;
    end else begin
      data_hit  <= rd_c;
      data_read <= rd_c ? reg_rdata_c : '0;
    end
  end

  // Divisor bytes; the transmitter picks up a new value at its next bit boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor <= DIV_W'(DIVISOR);
    end else if (wr_c) begin
      if (reg_sel_c == OFS_UBRR_L) begin
        divisor[7:0] <= data_write;
      end else if (reg_sel_c == OFS_UBRR_H) begin
        divisor[15:8] <= data_write;
      end
    end
  end

  // Sticky overflow: cleared by a USR read, a coincident new overflow wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (overflow & ~usr_rd_c) | ovf_set_c;
    end
  end

  // Interrupt level: nothing queued and nothing on the wire
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_empty <= 1'b1;
    end else begin
      irq_empty <= (fifo_count == '0) & (state == IDLE);
    end
  end

  // Transmitter next-state, datapath and FIFO pop
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    tx_n       = uart_tx;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shreg_n    = fifo_rdata;
          bit_cnt_n  = '0;
          baud_cnt_n = div_eff_c - DIV_W'(1);
          tx_n       = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = div_eff_c - DIV_W'(1);
          tx_n       = shreg[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = div_eff_c - DIV_W'(1);
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          state_n = IDLE;
        end else begin
          baud_cnt_n = baud_cnt - DIV_W'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // Transmitter state register; uart_tx comes straight from a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      uart_tx  <= tx_n;
    end
  end

endmodule

// File: tb/tb_avr_io_uart_tx.sv
// Directed bench for avr_io_uart_tx: register access, frame shape and timing,
// FIFO overflow, back-to-back spacing, asynchronous reset and address decode.
module tb_avr_io_uart_tx;

  localparam logic [15:0] BASE   = 16'hFF00;
  localparam logic [15:0] A_UDR  = BASE;
  localparam logic [15:0] A_USR  = BASE + 16'd1;
  localparam logic [15:0] A_UBRL = BASE + 16'd2;
  localparam logic [15:0] A_UBRH = BASE + 16'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_addr = '0;
  logic        data_wen = 1'b0;
  logic        data_ren = 1'b0;
  logic [7:0]  data_write = '0;
  logic [7:0]  data_read;
  logic        data_hit;
  logic        uart_tx;
  logic        irq_empty;

  int checks = 0;
  int failures = 0;

  // Serial monitor state
  bit          rx_en = 1'b0;
  int          rx_div = 1;
  int          rx_k = -1;
  logic [7:0]  rx_sh = '0;
  logic [7:0]  rx_q[$];
  int unsigned rx_start[$];
  int unsigned cyc = 0;
  int          rx_stop_err = 0;

  avr_io_uart_tx #(
    .ADDR_BASE  (BASE),
    .FIFO_DEPTH (16),
    .DIVISOR    (417)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_addr  (data_addr),
    .data_wen   (data_wen),
    .data_ren   (data_ren),
    .data_write (data_write),
    .data_read  (data_read),
    .data_hit   (data_hit),
    .uart_tx    (uart_tx),
    .irq_empty  (irq_empty)
  );

  always #5 clk = ~clk;

  // Receiver: start at first low sample, data at each bit's first negedge
  always @(negedge clk) begin
    cyc++;
    if (!rx_en) begin
      rx_k = -1;
    end else if (rx_k < 0) begin
      if (uart_tx === 1'b0) begin
        rx_k = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_k++;
      if (rx_k == 9 * rx_div) begin
        if (uart_tx !== 1'b1) rx_stop_err++;
        rx_q.push_back(rx_sh);
        rx_k = -1;
      end else if (rx_k % rx_div == 0) begin
        rx_sh = {uart_tx, rx_sh[7:1]};
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    data_addr  = a;
    data_write = d;
    data_wen   = 1'b1;
    @(negedge clk);
    data_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    data_addr = a;
    data_ren  = 1'b1;
    @(negedge clk);
    data_ren  = 1'b0;
    d = data_read;
    h = data_hit;
  endtask

  // Poll for a start bit at negedges, bounded
  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (uart_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rx(input int nbytes, input int limit);
    for (int n = 0; n < limit; n++) begin
      if (rx_q.size() >= nbytes) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d, d2;
    logic       h;
    logic [9:0] frame;
    logic [3:0] obs4;
    int         bad;
    bit         found;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_irq_empty", 32'(irq_empty), 32'd1);
    chk("rst_data_hit", 32'(data_hit), 32'd0);
    chk("rst_data_read", 32'(data_read), 32'd0);
    reset_n = 1'b1;

    // Idle line for 100 clocks
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || irq_empty !== 1'b1) bad++;
    end
    chk("idle100", 32'(bad), 32'd0);
    bus_read(A_USR, d, h);
    chk("usr_idle", 32'(d), 32'h02);
    chk("usr_idle_hit", 32'(h), 32'd1);

    // Single 0xA5 frame at 4 clocks per bit, USR sampled mid-frame
    bus_write(A_UBRL, 8'd4);
    bus_write(A_UBRH, 8'd0);
    bus_write(A_UDR, 8'hA5);
    wait_start(20, found);
    chk("a5_start_seen", 32'(found), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    d = '0;
    h = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < 4; s++) begin
        obs4[s] = uart_tx;
        if (b == 2 && s == 2) begin
          data_addr = A_USR;
          data_ren  = 1'b1;
        end
        if (b == 2 && s == 3) begin
          data_ren = 1'b0;
          d = data_read;
          h = data_hit;
        end
        @(negedge clk);
      end
      chk($sformatf("a5_bit%0d", b), 32'(obs4), {28'd0, {4{frame[b]}}});
    end
    chk("a5_line_idle_after", 32'(uart_tx), 32'd1);
    chk("a5_usr_busy", 32'(d), 32'h06);
    chk("a5_usr_busy_hit", 32'(h), 32'd1);
    repeat (3) @(negedge clk);
    chk("a5_irq_after", 32'(irq_empty), 32'd1);

    // Overflow: 18 back-to-back pushes, the first is popped at once so 0x11 is dropped
    bus_write(A_UBRL, 8'd2);
    rx_q.delete();
    rx_start.delete();
    rx_div = 2;
    rx_en  = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      data_addr  = A_UDR;
      data_write = 8'(i);
      data_wen   = 1'b1;
    end
    @(negedge clk);
    data_wen  = 1'b0;
    data_addr = A_USR;
    data_ren  = 1'b1;
    @(negedge clk);
    d = data_read;
    @(negedge clk);
    data_ren = 1'b0;
    d2 = data_read;
    chk("ovf_usr_set", 32'(d), 32'h0D);
    chk("ovf_usr_cleared", 32'(d2), 32'h05);
    wait_rx(17, 17 * 21 + 80);
    repeat (60) @(negedge clk);
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd17);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'(i)) bad++;
    chk("ovf_rx_order", 32'(bad), 32'd0);
    bus_read(A_USR, d, h);
    chk("ovf_usr_drained", 32'(d), 32'h02);

    // Divisor 1: three frames separated by exactly one idle clock
    bus_write(A_UBRL, 8'd1);
    rx_q.delete();
    rx_start.delete();
    rx_div = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_addr  = A_UDR;
      data_write = (i == 0) ? 8'h3C : (i == 1) ? 8'hC3 : 8'h81;
      data_wen   = 1'b1;
    end
    @(negedge clk);
    data_wen = 1'b0;
    wait_rx(3, 80);
    repeat (5) @(negedge clk);
    chk("div1_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3 && rx_start.size() == 3) begin
      chk("div1_byte0", 32'(rx_q[0]), 32'h3C);
      chk("div1_byte1", 32'(rx_q[1]), 32'hC3);
      chk("div1_byte2", 32'(rx_q[2]), 32'h81);
      chk("div1_gap01", rx_start[1] - rx_start[0], 32'd11);
      chk("div1_gap12", rx_start[2] - rx_start[1], 32'd11);
    end
    chk("rx_stop_bits", 32'(rx_stop_err), 32'd0);
    rx_en = 1'b0;

    // Asynchronous reset during data bit 3, with bytes still queued
    bus_write(A_UBRL, 8'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_addr  = A_UDR;
      data_write = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
      data_wen   = 1'b1;
    end
    @(negedge clk);
    data_wen = 1'b0;
    wait_start(20, found);
    chk("rst_frame_start_seen", 32'(found), 32'd1);
    repeat (17) @(negedge clk);
    chk("rst_bit3_low", 32'(uart_tx), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_tx_high", 32'(uart_tx), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_USR, d, h);
    chk("rst_usr", 32'(d), 32'h02);
    bus_read(A_UBRL, d, h);
    chk("rst_ubrr_l", 32'(d), 32'hA1);
    bus_read(A_UBRH, d, h);
    chk("rst_ubrr_h", 32'(d), 32'h01);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk("rst_fifo_flushed", 32'(bad), 32'd0);

    // Address decode
    bus_read(A_UDR, d, h);
    chk("udr_read_data", 32'(d), 32'h00);
    chk("udr_read_hit", 32'(h), 32'd1);
    bus_read(BASE + 16'd4, d, h);
    chk("oow_hi_data", 32'(d), 32'h00);
    chk("oow_hi_hit", 32'(h), 32'd0);
    bus_read(16'h0010, d, h);
    chk("ram_addr_data", 32'(d), 32'h00);
    chk("ram_addr_hit", 32'(h), 32'd0);
    bus_write(BASE + 16'd6, 8'h12);
    bus_write(BASE - 16'd2, 8'h33);
    bus_read(A_UBRL, d, h);
    chk("oow_write_ignored", 32'(d), 32'hA1);
    bus_read(A_USR, d, h);
    chk("oow_write_no_push", 32'(d), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
